// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: byte-stream sequencer for the bit-serial CRC-8 engine
// (x^8+x^4+1, zero init). Accepts one byte at a time, feeds it to the engine
// one bit per cycle, forwards the byte, then captures the CRC at frame end
// and clears the engine.
//
// Build option: define CRC_APPEND_EN to append the CRC as a trailing byte
// carrying m_last. Without it, the data byte carries m_last and the CRC is
// reported only on crc_result/crc_done.
module crc_frame_ctrl #(
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       eng_rst,
  output logic       eng_data_in,
  output logic       eng_data_valid,
  input  logic [7:0] eng_crc,
  output logic [7:0] crc_result,
  output logic       crc_done,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd1;
  localparam logic [2:0] ST_OUT   = 3'd2;
  localparam logic [2:0] ST_CRC   = 3'd3;
  localparam logic [2:0] ST_CLR   = 3'd4;

  localparam bit LP_MSB = (MSB_FIRST != 0);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_hold;
  logic       r_last;
  logic [7:0] r_crc_result;
  logic       r_crc_done;

  logic       w_s_hs;
  logic       w_m_hs;
  logic       w_crc_exit;

  assign w_s_hs = (r_state == ST_IDLE) && s_valid;
  assign w_m_hs = m_valid && m_ready;

`ifdef CRC_APPEND_EN
  // The CRC byte is a real output beat, so the CRC state waits for downstream.
  assign w_crc_exit = (r_state == ST_CRC) && m_ready;
`else
  // No CRC beat on the stream: the engine value is simply sampled for one cycle.
  assign w_crc_exit = (r_state == ST_CRC);
`endif

  // Next-state logic for the single-byte buffer sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_s_hs) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_bit_cnt == 3'd7) w_state_nxt = ST_OUT;
      ST_OUT:   if (w_m_hs) w_state_nxt = r_last ? ST_CRC : ST_IDLE;
      ST_CRC:   if (w_crc_exit) w_state_nxt = ST_CLR;
      ST_CLR:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Bit counter: restarts on acceptance, counts the eight SHIFT cycles.
  always_ff @(posedge clk) begin
    if (rst)                      r_bit_cnt <= 3'd0;
    else if (w_s_hs)              r_bit_cnt <= 3'd0;
    else if (r_state == ST_SHIFT) r_bit_cnt <= r_bit_cnt + 3'd1;
  end

  // Serializer: loaded on acceptance, moves one bit per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (w_s_hs) begin
      r_shift <= s_data;
    end else if (r_state == ST_SHIFT) begin
      if (LP_MSB) r_shift <= {r_shift[6:0], 1'b0};
      else        r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  // Output hold register and frame-end flag, captured with the accepted byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= 8'h00;
      r_last <= 1'b0;
    end else if (w_s_hs) begin
      r_hold <= s_data;
      r_last <= s_last;
    end
  end

  // CRC capture at frame end; done pulses in the CLR cycle alongside the new result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc_result <= 8'h00;
      r_crc_done   <= 1'b0;
    end else begin
      r_crc_done <= w_crc_exit;
      if (w_crc_exit) r_crc_result <= eng_crc;
    end
  end

  // Handshake, engine control and stream output decode from the current state.
  always_comb begin
    s_ready        = (r_state == ST_IDLE);
    busy           = (r_state != ST_IDLE);
    eng_rst        = rst || (r_state == ST_CLR);
    eng_data_valid = (r_state == ST_SHIFT);
    eng_data_in    = (r_state == ST_SHIFT) && (LP_MSB ? r_shift[7] : r_shift[0]);
`ifdef CRC_APPEND_EN
    m_valid        = (r_state == ST_OUT) || (r_state == ST_CRC);
    m_data         = (r_state == ST_CRC) ? eng_crc : r_hold;
    m_last         = (r_state == ST_CRC);
`else
    m_valid        = (r_state == ST_OUT);
    m_data         = r_hold;
    m_last         = (r_state == ST_OUT) && r_last;
`endif
    crc_result     = r_crc_result;
    crc_done       = r_crc_done;
  end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Testbench for crc_frame_ctrl. Contains a bit-serial CRC-8 engine model driven
// by the DUT's engine pins, a stream monitor, table-driven frames, cycle-exact
// corner-case sequences and randomized frames with random backpressure checked
// against a byte-level CRC reference.
`timescale 1ns/1ps
module tb_crc_frame_ctrl;

  localparam int MSB_FIRST = 1;
`ifdef CRC_APPEND_EN
  localparam bit APPEND = 1'b1;
`else
  localparam bit APPEND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready = 1'b1;
  logic       eng_rst;
  logic       eng_data_in;
  logic       eng_data_valid;
  logic [7:0] eng_crc;
  logic [7:0] crc_result;
  logic       crc_done;
  logic       busy;

  crc_frame_ctrl #(.MSB_FIRST(MSB_FIRST)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .eng_rst(eng_rst), .eng_data_in(eng_data_in), .eng_data_valid(eng_data_valid),
    .eng_crc(eng_crc), .crc_result(crc_result), .crc_done(crc_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bit-serial CRC-8 engine the controller drives.
  always_ff @(posedge clk) begin
    if (eng_rst)             eng_crc <= 8'h00;
    else if (eng_data_valid) eng_crc <= {eng_crc[6:0], 1'b0} ^ ((eng_crc[7] ^ eng_data_in) ? 8'h11 : 8'h00);
  end

  logic [8:0] out_q[$];
  logic [7:0] crc_q[$];

  // Record every output beat and every crc_done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) out_q.push_back({m_last, m_data});
      if (crc_done)           crc_q.push_back(crc_result);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [7:0] fr[16];

  function automatic logic [7:0] crc_ref(input int n);
    logic [7:0] c;
    logic       b;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        b = (MSB_FIRST != 0) ? fr[i][7-k] : fr[i][k];
        c = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h11 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic accept_byte(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    @(posedge clk); #1;
    s_data = d; s_last = l; s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) check("accept_timeout", 32'(s_ready), 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = 8'($urandom);
    s_last  = 1'($urandom);
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) accept_byte(fr[i], (i == n - 1));
  endtask

  task automatic wait_crc();
    int t;
    t = 0;
    while (crc_q.size() == 0 && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    check("crc_done_seen", 32'(crc_q.size() != 0), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input int n, input logic [7:0] exp_crc);
    int exp_n;
    logic [8:0] e;
    exp_n = n + int'(APPEND);
    check("out_count", out_q.size(), exp_n);
    for (int i = 0; i < exp_n && i < out_q.size(); i++) begin
      if (i < n) e = {(!APPEND && i == n - 1), fr[i]};
      else       e = {1'b1, exp_crc};
      check($sformatf("out_beat%0d", i), 32'(out_q[i]), 32'(e));
    end
    check("crc_pulses", crc_q.size(), 1);
    if (crc_q.size() > 0) check("crc_at_done", 32'(crc_q[0]), 32'(exp_crc));
    check("crc_result_hold", 32'(crc_result), 32'(exp_crc));
    out_q.delete();
    crc_q.delete();
  endtask

  typedef struct {
    int          len;
    logic [31:0] bytes;
    logic [7:0]  exp_crc;
  } vec_t;

  vec_t tbl[8];
  bit   bp_on;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table: frames (byte 0 in the low byte) and expected CRC, MSB first.
    tbl[0] = '{1, 32'h0000_0001, 8'h11};
    tbl[1] = '{1, 32'h0000_0080, 8'h08};
    tbl[2] = '{2, 32'h0000_0880, 8'h00};
    tbl[3] = '{1, 32'h0000_0001, 8'h11};
    tbl[4] = '{1, 32'h0000_0000, 8'h00};
    tbl[5] = '{1, 32'h0000_0002, 8'h22};
    tbl[6] = '{1, 32'h0000_0010, 8'h01};
    tbl[7] = '{2, 32'h0000_0101, 8'h01};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_eng_rst", 32'(eng_rst), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_eng_dv", 32'(eng_data_valid), 0);
    check("rst_eng_din", 32'(eng_data_in), 0);
    check("rst_crc_result", 32'(crc_result), 0);
    check("rst_crc_done", 32'(crc_done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", 32'(s_ready), 1);
    check("post_rst_eng_rst", 32'(eng_rst), 0);

    // Single byte 0x80: cycle-exact latency and serial bit order.
    out_q.delete(); crc_q.delete();
    fr[0] = 8'h80;
    accept_byte(8'h80, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c <= 8) begin
        check($sformatf("shift%0d_dv", c), 32'(eng_data_valid), 1);
        check($sformatf("shift%0d_bit", c), 32'(eng_data_in), 32'(fr[0][8-c]));
        check($sformatf("shift%0d_mvalid", c), 32'(m_valid), 0);
        check($sformatf("shift%0d_sready", c), 32'(s_ready), 0);
      end else if (c == 9) begin
        check("out_mvalid", 32'(m_valid), 1);
        check("out_mdata", 32'(m_data), 'h80);
        check("out_mlast", 32'(m_last), 32'(!APPEND));
        check("out_dv", 32'(eng_data_valid), 0);
      end else if (c == 10) begin
        check("crcst_mvalid", 32'(m_valid), 32'(APPEND));
        check("crcst_busy", 32'(busy), 1);
      end else if (c == 11) begin
        check("clr_done", 32'(crc_done), 1);
        check("clr_result", 32'(crc_result), 'h08);
        check("clr_eng_rst", 32'(eng_rst), 1);
      end else begin
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(crc_done), 0);
        check("idle_sready", 32'(s_ready), 1);
      end
    end
    check_frame(1, 8'h08);

    // Backpressure in OUT and CRC.
    fr[0] = 8'h01;
    m_ready = 1'b0;
    accept_byte(8'h01, 1'b1);
    repeat (8) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_mvalid", 32'(m_valid), 1);
      check("bp_out_mdata", 32'(m_data), 'h01);
      check("bp_out_dv", 32'(eng_data_valid), 0);
      check("bp_out_sready", 32'(s_ready), 0);
      check("bp_out_eng", 32'(eng_crc), 'h11);
    end
    @(posedge clk); #1; m_ready = 1'b1;
    @(posedge clk); #1; m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_crc_mvalid", 32'(m_valid), 32'(APPEND));
      check("bp_crc_dv", 32'(eng_data_valid), 0);
      check("bp_crc_sready", 32'(s_ready), 32'(!APPEND && k >= 2));
      check("bp_crc_done", 32'(crc_done), 32'(!APPEND && k == 1));
      if (m_valid) check("bp_crc_mdata", 32'(m_data), 'h11);
    end
    @(posedge clk); #1; m_ready = 1'b1;
    wait_crc();
    check_frame(1, 8'h11);

    // Reset in the 4th SHIFT cycle.
    accept_byte(8'h01, 1'b1);
    repeat (4) @(negedge clk);
    check("rs_in_shift", 32'(eng_data_valid), 1);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rs_busy", 32'(busy), 0);
    check("rs_eng_rst", 32'(eng_rst), 1);
    check("rs_dv", 32'(eng_data_valid), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rs_crc_result", 32'(crc_result), 0);
    check("rs_eng_cleared", 32'(eng_crc), 0);
    check("rs_sready", 32'(s_ready), 1);
    repeat (15) @(negedge clk);
    check("rs_no_done", crc_q.size(), 0);
    check("rs_no_out", out_q.size(), 0);
    out_q.delete(); crc_q.delete();

    // Table-driven frames, back to back, m_ready high.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < tbl[v].len; i++) fr[i] = tbl[v].bytes[8*i +: 8];
      send_frame(tbl[v].len);
      wait_crc();
      check_frame(tbl[v].len, tbl[v].exp_crc);
    end

    // Randomized frames with random downstream stalls.
    for (int f = 0; f < 40; f++) begin
      int n;
      logic [7:0] exp_crc;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) fr[i] = 8'($urandom);
      exp_crc = crc_ref(n);
      bp_on = 1'b1;
      fork
        begin
          send_frame(n);
          wait_crc();
          bp_on = 1'b0;
        end
        begin
          while (bp_on) begin
            @(posedge clk); #1;
            m_ready = ($urandom_range(0, 3) != 0);
          end
        end
      join
      @(posedge clk); #1; m_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_frame(n, exp_crc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
